// File: rtl/uart_host_tx.sv
// Host-side UART transmitter: byte FIFO with valid/ready input, serialised
// LSB-first as start/data/[parity]/stop frames at a runtime bit period.
`timescale 1ns/1ps
module uart_host_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [15:0]                   div_i,
    input  logic [7:0]                    data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int   PTR_W   = $clog2(FIFO_DEPTH);
    localparam int   CNT_W   = PTR_W + 1;
    localparam logic PAR_EN  = (PARITY_EN != 0);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic parity_of(input logic [7:0] b, input logic odd);
        return (^b) ^ odd;
    endfunction

    state_t             state_r, state_s;
    logic [7:0]         mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [7:0]         shift_r;
    logic               par_r;
    logic [15:0]        div_r;
    logic [16:0]        cnt_r, cnt_s;
    logic [2:0]         idx_r, idx_s;
    logic               tx_r, tx_s;
    logic               pop_s, push_s, shift_en_s;
    logic [7:0]         head_s;
    logic [15:0]        div_load_s;
    logic [16:0]        load_cnt_s, bit_cnt_s, stop_cnt_s;

    assign push_s     = valid_i && ready_o;
    assign head_s     = mem_r[rd_ptr_r];
    assign div_load_s = (div_i == 16'd0) ? 16'd1 : div_i;
    assign load_cnt_s = {1'b0, div_load_s} - 17'd1;
    assign bit_cnt_s  = {1'b0, div_r} - 17'd1;
    // Stop phase is one counter run covering all stop bits.
    assign stop_cnt_s = ((STOP_BITS == 2) ? {div_r, 1'b0} : {1'b0, div_r}) - 17'd1;

    assign ready_o      = (count_r != CNT_W'(FIFO_DEPTH));
    assign busy_o       = (state_r != ST_IDLE) || (count_r != {CNT_W{1'b0}});
    assign fifo_count_o = count_r;
    assign tx_o         = tx_r;

    // Next-state, bit-counter and line-level decode for the frame FSM.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        idx_s      = idx_r;
        tx_s       = 1'b1;
        pop_s      = 1'b0;
        shift_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (count_r != {CNT_W{1'b0}}) begin
                    pop_s   = 1'b1;
                    cnt_s   = load_cnt_s;
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                tx_s = 1'b0;
                if (cnt_r == 17'd0) begin
                    cnt_s   = bit_cnt_s;
                    idx_s   = 3'd0;
                    state_s = ST_DATA;
                end else begin
                    cnt_s = cnt_r - 17'd1;
                end
            end
            ST_DATA: begin
                tx_s = shift_r[0];
                if (cnt_r == 17'd0) begin
                    shift_en_s = 1'b1;
                    if (idx_r == 3'd7) begin
                        if (PAR_EN) begin
                            cnt_s   = bit_cnt_s;
                            state_s = ST_PARITY;
                        end else begin
                            cnt_s   = stop_cnt_s;
                            state_s = ST_STOP;
                        end
                    end else begin
                        idx_s = idx_r + 3'd1;
                        cnt_s = bit_cnt_s;
                    end
                end else begin
                    cnt_s = cnt_r - 17'd1;
                end
            end
            ST_PARITY: begin
                tx_s = par_r;
                if (cnt_r == 17'd0) begin
                    cnt_s   = stop_cnt_s;
                    state_s = ST_STOP;
                end else begin
                    cnt_s = cnt_r - 17'd1;
                end
            end
            ST_STOP: begin
                tx_s = 1'b1;
                if (cnt_r == 17'd0) begin
                    // Chain straight into the next frame when data is waiting.
                    if (count_r != {CNT_W{1'b0}}) begin
                        pop_s   = 1'b1;
                        cnt_s   = load_cnt_s;
                        state_s = ST_START;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r - 17'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Frame FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Frame datapath: bit timer, shift register, latched divider and line flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r   <= 17'd0;
            idx_r   <= 3'd0;
            shift_r <= 8'd0;
            par_r   <= 1'b0;
            div_r   <= 16'd1;
            tx_r    <= 1'b1;
        end else begin
            cnt_r <= cnt_s;
            idx_r <= idx_s;
            tx_r  <= tx_s;
            if (pop_s) begin
                shift_r <= head_s;
                par_r   <= parity_of(head_s, PAR_ODD);
                div_r   <= div_load_s;
            end else if (shift_en_s) begin
                shift_r <= {1'b0, shift_r[7:1]};
            end
        end
    end

    // Byte FIFO storage, pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'd0;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= data_i;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule
